// File: rtl/pipe_regfile_pkg.sv
// Shared defaults and write-forwarding priority for the pipeline register file.
package pipe_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int MAX_A      = 16;

  typedef enum logic [1:0] {
    SEL_MEM = 2'd0,
    SEL_P1  = 2'd1,
    SEL_P2  = 2'd2
  } fwd_sel_t;

  // Source of a register's next value: port 2 beats port 1 beats the stored copy.
  function automatic fwd_sel_t fwd_sel(
    input logic [MAX_A-1:0] addr,
    input logic             we1,
    input logic [MAX_A-1:0] wa1,
    input logic             we2,
    input logic [MAX_A-1:0] wa2
  );
    if (we2 && (wa2 == addr))      return SEL_P2;
    else if (we1 && (wa1 == addr)) return SEL_P1;
    else                           return SEL_MEM;
  endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// Decode/write-back facing bus of the register file; master drives, slave is the regfile.
interface pipe_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              we1;
  logic              we2;
  logic [ADDR_W-1:0] wr_addr1;
  logic [ADDR_W-1:0] wr_addr2;
  logic [DATA_W-1:0] wr_data1;
  logic [DATA_W-1:0] wr_data2;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic [DATA_W-1:0] mon_data;

  modport master (
    output rd_en, rd_addr1, rd_addr2, we1, we2, wr_addr1, wr_addr2,
           wr_data1, wr_data2, claim_en, claim_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, mon_data
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, we1, we2, wr_addr1, wr_addr2,
           wr_data1, wr_data2, claim_en, claim_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, mon_data
  );
endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// Per-register pending-write bits with registered busy lookups for the two read ports.
// Latency 1 edge; busy outputs hold while i_rd_en is low.
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_wr_addr1,
  input  logic              i_we2,
  input  logic [ADDR_W-1:0] i_wr_addr2,
  input  logic              i_claim_en,
  input  logic [ADDR_W-1:0] i_claim_addr,
  output logic              o_busy1,
  output logic              o_busy2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             r_busy1;
  logic             r_busy2;

  // A claim on the same edge as a write means a newer producer is outstanding.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_claim_en && (i_claim_addr == ADDR_W'(i)))
        w_pend_nxt[i] = 1'b1;
      else if (fwd_sel(MAX_A'(i), i_we1, MAX_A'(i_wr_addr1),
                       i_we2, MAX_A'(i_wr_addr2)) != SEL_MEM)
        w_pend_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= '0;
      r_busy1 <= 1'b0;
      r_busy2 <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (i_rd_en) begin
        r_busy1 <= w_pend_nxt[i_rd_addr1];
        r_busy2 <= w_pend_nxt[i_rd_addr2];
      end
    end
  end

  assign o_busy1 = r_busy1;
  assign o_busy2 = r_busy2;

endmodule

// File: rtl/pipe_regfile.sv
// Two-read/two-write register file with full write-to-read forwarding, RAW scoreboard
// and a registered monitor tap. Read latency 1 edge; outputs hold while rd_en is low.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MON_REG   = 15,
  parameter int ZERO_REG0 = 0
) (
  input  logic           clk,
  input  logic           rst,
  pipe_regfile_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] MON_IDX = ADDR_W'(MON_REG);

  logic [DATA_W-1:0] r_mem     [DEPTH];
  logic [DATA_W-1:0] w_mem_nxt [DEPTH];
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_mon;
  logic              w_we1;
  logic              w_we2;
  logic              w_claim;
  logic              w_busy1;
  logic              w_busy2;

  // With a hard-wired zero register, address-0 traffic is dropped before it
  // reaches storage, forwarding or the scoreboard, so reg 0 stays 0 and idle.
  always_comb begin
    w_we1   = bus.we1;
    w_we2   = bus.we2;
    w_claim = bus.claim_en;
    if (ZERO_REG0 != 0) begin
      if (bus.wr_addr1 == '0)   w_we1   = 1'b0;
      if (bus.wr_addr2 == '0)   w_we2   = 1'b0;
      if (bus.claim_addr == '0) w_claim = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = r_mem[i];
      case (fwd_sel(MAX_A'(i), w_we1, MAX_A'(bus.wr_addr1),
                    w_we2, MAX_A'(bus.wr_addr2)))
        SEL_P2:  w_mem_nxt[i] = bus.wr_data2;
        SEL_P1:  w_mem_nxt[i] = bus.wr_data1;
        default: w_mem_nxt[i] = r_mem[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_mon <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_nxt[i];
      r_mon <= w_mem_nxt[MON_IDX];
      if (bus.rd_en) begin
        r_rd1 <= w_mem_nxt[bus.rd_addr1];
        r_rd2 <= w_mem_nxt[bus.rd_addr2];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_rd_en      (bus.rd_en),
    .i_rd_addr1   (bus.rd_addr1),
    .i_rd_addr2   (bus.rd_addr2),
    .i_we1        (w_we1),
    .i_wr_addr1   (bus.wr_addr1),
    .i_we2        (w_we2),
    .i_wr_addr2   (bus.wr_addr2),
    .i_claim_en   (w_claim),
    .i_claim_addr (bus.claim_addr),
    .o_busy1      (w_busy1),
    .o_busy2      (w_busy2)
  );

  assign bus.rd_data1 = r_rd1;
  assign bus.rd_data2 = r_rd2;
  assign bus.rd_busy1 = w_busy1;
  assign bus.rd_busy2 = w_busy2;
  assign bus.mon_data = r_mon;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench: default build (m) and zero-register build (z) share one stimulus stream.
module tb_pipe_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_regfile_if #(.DATA_W(16), .ADDR_W(4)) m_if ();
  pipe_regfile_if #(.DATA_W(16), .ADDR_W(4)) z_if ();

  assign z_if.rd_en      = m_if.rd_en;
  assign z_if.rd_addr1   = m_if.rd_addr1;
  assign z_if.rd_addr2   = m_if.rd_addr2;
  assign z_if.we1        = m_if.we1;
  assign z_if.we2        = m_if.we2;
  assign z_if.wr_addr1   = m_if.wr_addr1;
  assign z_if.wr_addr2   = m_if.wr_addr2;
  assign z_if.wr_data1   = m_if.wr_data1;
  assign z_if.wr_data2   = m_if.wr_data2;
  assign z_if.claim_en   = m_if.claim_en;
  assign z_if.claim_addr = m_if.claim_addr;

  pipe_regfile #(.DATA_W(16), .ADDR_W(4), .MON_REG(15), .ZERO_REG0(0)) u_m (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  pipe_regfile #(.DATA_W(16), .ADDR_W(4), .MON_REG(15), .ZERO_REG0(1)) u_z (
    .clk (clk), .rst (rst), .bus (z_if)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_if.we1      = 1'b0;
    m_if.we2      = 1'b0;
    m_if.claim_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_d1"}, m_if.rd_data1, 16'h0000);
    chk({tag, "_m_d2"}, m_if.rd_data2, 16'h0000);
    chk({tag, "_m_b1"}, {15'd0, m_if.rd_busy1}, 16'h0000);
    chk({tag, "_m_b2"}, {15'd0, m_if.rd_busy2}, 16'h0000);
    chk({tag, "_m_mon"}, m_if.mon_data, 16'h0000);
    chk({tag, "_z_d1"}, z_if.rd_data1, 16'h0000);
    chk({tag, "_z_mon"}, z_if.mon_data, 16'h0000);
  endtask

  initial begin
    m_if.rd_en      = 1'b0;
    m_if.rd_addr1   = '0;
    m_if.rd_addr2   = '0;
    m_if.we1        = 1'b0;
    m_if.we2        = 1'b0;
    m_if.wr_addr1   = '0;
    m_if.wr_addr2   = '0;
    m_if.wr_data1   = '0;
    m_if.wr_data2   = '0;
    m_if.claim_en   = 1'b0;
    m_if.claim_addr = '0;

    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b1;

    // reads of 0 and 15 after reset
    m_if.rd_en = 1'b1; m_if.rd_addr1 = 4'd0; m_if.rd_addr2 = 4'd15;
    tick();
    chk_all_zero("rd0_15");

    // same-address dual write: port 2 wins
    m_if.rd_en = 1'b0;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd3; m_if.wr_data1 = 16'h1234;
    m_if.we2 = 1'b1; m_if.wr_addr2 = 4'd3; m_if.wr_data2 = 16'hABCD;
    tick();
    idle();
    m_if.rd_en = 1'b1; m_if.rd_addr1 = 4'd3;
    tick();
    chk("conflict_p2", m_if.rd_data1, 16'hABCD);

    // port 2 alone
    m_if.rd_en = 1'b0;
    m_if.we2 = 1'b1; m_if.wr_addr2 = 4'd5; m_if.wr_data2 = 16'h0055;
    tick();
    idle();
    m_if.rd_en = 1'b1; m_if.rd_addr2 = 4'd5;
    tick();
    chk("we2_only", m_if.rd_data2, 16'h0055);
    chk("rd1_still3", m_if.rd_data1, 16'hABCD);

    // same-cycle forwarding
    m_if.rd_addr1 = 4'd7;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd7; m_if.wr_data1 = 16'h7777;
    tick();
    chk("fwd_p1", m_if.rd_data1, 16'h7777);

    // rd_en=0 holds outputs while a write still lands
    m_if.rd_en = 1'b0; m_if.rd_addr1 = 4'd3;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd6; m_if.wr_data1 = 16'h0066;
    tick();
    chk("hold_d1", m_if.rd_data1, 16'h7777);
    chk("hold_d2", m_if.rd_data2, 16'h0055);
    idle();
    m_if.rd_en = 1'b1; m_if.rd_addr1 = 4'd6;
    tick();
    chk("wr_during_hold", m_if.rd_data1, 16'h0066);

    // scoreboard: claim visible to same-cycle read
    m_if.claim_en = 1'b1; m_if.claim_addr = 4'd9; m_if.rd_addr1 = 4'd9;
    tick();
    chk("claim_busy", {15'd0, m_if.rd_busy1}, 16'h0001);
    chk("other_idle", {15'd0, m_if.rd_busy2}, 16'h0000);
    idle();
    tick();
    chk("claim_persist", {15'd0, m_if.rd_busy1}, 16'h0001);

    // clearing write: same-cycle read sees busy=0 and new data
    m_if.we2 = 1'b1; m_if.wr_addr2 = 4'd9; m_if.wr_data2 = 16'h0999;
    tick();
    chk("clear_busy", {15'd0, m_if.rd_busy1}, 16'h0000);
    chk("clear_data", m_if.rd_data1, 16'h0999);

    // claim and write on the same edge: claim wins
    idle();
    m_if.claim_en = 1'b1; m_if.claim_addr = 4'd9;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd9; m_if.wr_data1 = 16'h1999;
    tick();
    chk("claimwr_busy", {15'd0, m_if.rd_busy1}, 16'h0001);
    chk("claimwr_data", m_if.rd_data1, 16'h1999);
    idle();
    tick();
    chk("claimwr_persist", {15'd0, m_if.rd_busy1}, 16'h0001);

    // monitor tracks reg 15 with reads disabled
    m_if.rd_en = 1'b0;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd15; m_if.wr_data1 = 16'hBEEF;
    tick();
    chk("mon_m", m_if.mon_data, 16'hBEEF);
    chk("mon_z", z_if.mon_data, 16'hBEEF);
    chk("mon_hold_d1", m_if.rd_data1, 16'h1999);
    idle();

    // writes and claims to address 0: dropped only in the zero-register build
    m_if.rd_en = 1'b1; m_if.rd_addr1 = 4'd0;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd0; m_if.wr_data1 = 16'hFFFF;
    m_if.claim_en = 1'b1; m_if.claim_addr = 4'd0;
    tick();
    chk("z_r0_data", z_if.rd_data1, 16'h0000);
    chk("z_r0_busy", {15'd0, z_if.rd_busy1}, 16'h0000);
    chk("m_r0_data", m_if.rd_data1, 16'hFFFF);
    chk("m_r0_busy", {15'd0, m_if.rd_busy1}, 16'h0001);
    idle();
    m_if.we2 = 1'b1; m_if.wr_addr2 = 4'd0; m_if.wr_data2 = 16'h0F0F;
    tick();
    chk("z_r0_we2", z_if.rd_data1, 16'h0000);
    chk("m_r0_we2", m_if.rd_data1, 16'h0F0F);
    idle();

    // asynchronous reset mid-sequence
    m_if.rd_addr1 = 4'd9; m_if.rd_addr2 = 4'd5;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("arst");
    tick();
    chk_all_zero("arst_held");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_all_zero("post_rst");

    // first edges after reset behave normally
    m_if.rd_addr1 = 4'd2;
    m_if.we1 = 1'b1; m_if.wr_addr1 = 4'd2; m_if.wr_data1 = 16'h2222;
    tick();
    chk("post_rst_fwd", m_if.rd_data1, 16'h2222);
    idle();
    m_if.rd_addr1 = 4'd15;
    tick();
    chk("post_rst_r15", m_if.rd_data1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised two-read / two-write register file for the 5-stage datapath, sitting between decode (reads) and write-back (writes). Reads are registered with an explicit read enable, write-to-read forwarding, and independent write enables. A per-register pending-write scoreboard lets decode detect RAW hazards. A registered monitor port exposes one selectable register.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- MON_REG, 15, index of the register driven on mon_data
- ZERO_REG0, 0, when 1 register 0 reads as zero, ignores writes and is never busy
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  when 1, read ports sample on this edge; when 0, read outputs hold
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  registered read data
- rd_busy1, rd_busy2  out  1  registered pending-write flag of the addressed register
- we1, we2  in  1  independent write enables
- wr_addr1, wr_addr2  in  ADDR_W  write addresses
- wr_data1, wr_data2  in  DATA_W  write data
- claim_en  in  1  marks claim_addr as pending (destination issued)
- claim_addr  in  ADDR_W  register being claimed
- mon_data  out  DATA_W  registered copy of register MON_REG

## Operation
- Reset (rst=0, asynchronous): all DEPTH registers = 0, all pending bits = 0, rd_data1/2 = 0, rd_busy1/2 = 0, mon_data = 0. Held while rst=0.
- Writes: on an edge with weN=1, register[wr_addrN] <= wr_dataN. The enables are fully independent; we2 does not require we1.
- Write conflict: if we1 and we2 target the same address, port 2 wins.
- Read: on an edge with rd_en=1, rd_dataK <= next value of register[rd_addrK]. "Next value" means port 2 write data if matched, else port 1 write data if matched, else the stored value. This is full write-to-read forwarding.
- rd_en=0: rd_data and rd_busy hold their values, and writes still occur.
- Scoreboard, per register, one pending bit:
  - Set on an edge with claim_en=1 at claim_addr.
  - Cleared on an edge with a write (either port) to that address.
  - If a claim and a write hit the same address on the same edge, the claim wins and the bit is 1, since the new producer is outstanding.
  - rd_busyK <= next pending bit of rd_addrK (with the same forwarding rule) when rd_en=1.
- ZERO_REG0=1: writes and claims to address 0 are dropped, and reads of address 0 return 0 with busy=0, including the forwarding path.
- mon_data <= next value of register[MON_REG] on every edge, regardless of rd_en. It therefore always equals the stored register content.

## Timing
- Read latency is 1 edge: address is presented in cycle N with rd_en=1, and data is valid in cycle N+1.
- A write in cycle N is visible on a read issued in cycle N (forwarded) and in every later cycle.
- A claim in cycle N produces rd_busy=1 for reads of that address issued in cycle N or later, until the clearing write's edge. A read in the clearing write's cycle returns busy=0.
- mon_data lags the array by 0 edges: it updates on the same edge as the write to MON_REG.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves normally.
- There are no combinational paths from inputs to outputs.

## Structure
- The package pipe_regfile_pkg holds:
  - default DATA_W/ADDR_W localparams;
  - a next-value function implementing the port-2 > port-1 > stored priority, reused for the data, busy and monitor paths.
- Sub-module regfile_scoreboard contains:
  - the DEPTH-bit pending vector with claim/clear logic;
  - two registered busy outputs gated by rd_en.
- The top level holds the storage array, forwarding muxes and the monitor register.

## Test plan
- Reset, then read addresses 0 and 15: rd_data1/2 = 0x0000, rd_busy = 0, mon_data = 0x0000.
- Dual write: we1 writes 0x1234 to addr 3 and we2 writes 0xABCD to addr 3 on the same edge. A next-cycle read of 3 returns 0xABCD. Also write we2 alone to addr 5 = 0x0055 and confirm it is stored.
- Forwarding: in one cycle, read addr 7 while we1 writes 0x7777 to addr 7 → rd_data1 = 0x7777 in the following cycle. With rd_en=0 the previous output holds.
- Scoreboard: claim addr 9 → a read of 9 shows busy=1. Write 9 → busy=0 in the same-cycle read. Claim and write 9 on the same edge → busy stays 1.
- Monitor: write 0xBEEF to addr 15 → mon_data = 0xBEEF after that edge, with rd_en=0 throughout.
- ZERO_REG0=1 build: write 0xFFFF and claim addr 0 → read returns 0x0000, busy=0. Then assert rst mid-sequence → all outputs return to 0 asynchronously.
